alu_seq: RTL

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_pkg.sv | 20 ++
 rtl/alu_muldiv_core.sv | 79 +++++++
 rtl/alu_seq.sv | 135 +++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcodes and FSM state encoding shared by the sequential ALU
package alu_pkg;

   localparam logic [3:0] OP_AND   = 4'b0000;
   localparam logic [3:0] OP_OR    = 4'b0001;
   localparam logic [3:0] OP_ADD   = 4'b0010;
   localparam logic [3:0] OP_SUB   = 4'b0110;
   localparam logic [3:0] OP_SLT   = 4'b0111;
   localparam logic [3:0] OP_NOR   = 4'b1100;
   localparam logic [3:0] OP_MULTU = 4'b1000;
   localparam logic [3:0] OP_DIVU  = 4'b1001;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

endpackage

// File: rtl/alu_muldiv_core.sv
// rtl/alu_muldiv_core.sv - iterative shift-add multiplier / restoring divider
module alu_muldiv_core #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_start,
   input  logic             i_div,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic             o_done,
   output logic [WIDTH-1:0] o_lo,
   output logic [WIDTH-1:0] o_hi
);

   localparam int CW = $clog2(WIDTH) + 1;

   logic             r_run;
   logic             r_div;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_lo;
   logic [WIDTH-1:0] r_hi;
   logic [WIDTH-1:0] r_b;

   logic [WIDTH:0]   w_sum;
   logic [WIDTH:0]   w_rem;
   logic [WIDTH-1:0] w_diff;
   logic             w_ge;
   logic [WIDTH-1:0] w_lo_nxt;
   logic [WIDTH-1:0] w_hi_nxt;

   // One iteration step: multiply shifts {hi,lo} right after a conditional add,
   // divide shifts {rem,quot} left and restores when the trial subtract underflows.
   // o_lo/o_hi expose the post-step values so the final step can be captured
   // by the parent on the same edge the core finishes.
   always_comb begin
      w_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : {(WIDTH+1){1'b0}});
      w_rem  = {r_hi, r_lo[WIDTH-1]};
      w_ge   = (w_rem >= {1'b0, r_b});
      w_diff = w_rem[WIDTH-1:0] - r_b;
      if (r_div) begin
         w_hi_nxt = w_ge ? w_diff : w_rem[WIDTH-1:0];
         w_lo_nxt = {r_lo[WIDTH-2:0], w_ge};
      end else begin
         w_hi_nxt = w_sum[WIDTH:1];
         w_lo_nxt = {w_sum[0], r_lo[WIDTH-1:1]};
      end
      o_done = r_run && (r_cnt == CW'(WIDTH - 1));
      o_lo   = w_lo_nxt;
      o_hi   = w_hi_nxt;
   end

   // Operand load on start, then exactly WIDTH iteration edges.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_run <= 1'b0;
         r_div <= 1'b0;
         r_cnt <= '0;
         r_lo  <= '0;
         r_hi  <= '0;
         r_b   <= '0;
      end else if (i_start) begin
         r_run <= 1'b1;
         r_div <= i_div;
         r_cnt <= '0;
         r_lo  <= i_a;
         r_hi  <= '0;
         r_b   <= i_b;
      end else if (r_run) begin
         r_lo  <= w_lo_nxt;
         r_hi  <= w_hi_nxt;
         r_cnt <= r_cnt + CW'(1);
         if (o_done) begin
            r_run <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - sequential ALU with single-cycle logic ops and iterative MULTU/DIVU
module alu_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [3:0]       select,
   input  logic [WIDTH-1:0] first,
   input  logic [WIDTH-1:0] second,
   output logic [WIDTH-1:0] out,
   output logic [WIDTH-1:0] hi,
   output logic             zero,
   output logic             busy,
   output logic             done
);

   state_t           r_state;
   state_t           w_next_state;
   logic [WIDTH-1:0] r_out;
   logic [WIDTH-1:0] r_hi;
   logic             r_zero;
   logic             r_busy;
   logic             r_done;

   logic             w_load;
   logic [WIDTH-1:0] w_res_lo;
   logic [WIDTH-1:0] w_res_hi;
   logic             w_core_start;
   logic             w_core_div;
   logic             w_core_done;
   logic [WIDTH-1:0] w_core_lo;
   logic [WIDTH-1:0] w_core_hi;

   // Single-cycle operations; MULTU/DIVU and undefined codes fall to zero here.
   function automatic logic [WIDTH-1:0] f_simple(input logic [3:0] op,
                                                 input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
      logic [WIDTH-1:0] r;
      r = '0;
      case (op)
         OP_AND: r = a & b;
         OP_OR:  r = a | b;
         OP_ADD: r = a + b;
         OP_SUB: r = a - b;
         OP_SLT: r = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         OP_NOR: r = ~(a | b);
         default: r = '0;
      endcase
      return r;
   endfunction

   alu_muldiv_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_start (w_core_start),
      .i_div   (w_core_div),
      .i_a     (first),
      .i_b     (second),
      .o_done  (w_core_done),
      .o_lo    (w_core_lo),
      .o_hi    (w_core_hi)
   );

   // Next-state and result-load decode; the result register is written on the
   // edge that enters DONE so it is valid for the whole done cycle.
   always_comb begin
      w_next_state = r_state;
      w_load       = 1'b0;
      w_res_lo     = '0;
      w_res_hi     = '0;
      w_core_start = 1'b0;
      w_core_div   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               if (select == OP_MULTU) begin
                  w_next_state = ST_MUL;
                  w_core_start = 1'b1;
               end else if (select == OP_DIVU) begin
                  w_next_state = ST_DIV;
                  w_core_start = 1'b1;
                  w_core_div   = 1'b1;
               end else begin
                  w_next_state = ST_DONE;
                  w_load       = 1'b1;
                  w_res_lo     = f_simple(select, first, second);
               end
            end
         end
         ST_MUL, ST_DIV: begin
            if (w_core_done) begin
               w_next_state = ST_DONE;
               w_load       = 1'b1;
               w_res_lo     = w_core_lo;
               w_res_hi     = w_core_hi;
            end
         end
         ST_DONE: w_next_state = ST_IDLE;
         default: w_next_state = ST_IDLE;
      endcase
   end

   // State, status flags and held results.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_out   <= '0;
         r_hi    <= '0;
         r_zero  <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_next_state;
         r_busy  <= (w_next_state == ST_MUL) || (w_next_state == ST_DIV);
         r_done  <= (w_next_state == ST_DONE);
         if (w_load) begin
            r_out  <= w_res_lo;
            r_hi   <= w_res_hi;
            r_zero <= (w_res_lo == '0);
         end
      end
   end

   assign out  = r_out;
   assign hi   = r_hi;
   assign zero = r_zero;
   assign busy = r_busy;
   assign done = r_done;

endmodule
